// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer (IF/ID/EX/MEM/WB) with halt handling,
// a per-phase watchdog and a wrapping retired-instruction counter.
module phase_sequencer #(
    parameter int COUNT_W        = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               halt,
    input  logic               if_done,
    input  logic               id_done,
    input  logic               ex_done,
    input  logic               mem_done,
    input  logic               wb_done,
    input  logic               need_mem,
    output logic               phase_if,
    output logic               phase_id,
    output logic               phase_ex,
    output logic               phase_mem,
    output logic               phase_wb,
    output logic               phase_start,
    output logic               busy,
    output logic               halted,
    output logic               timeout,
    output logic [COUNT_W-1:0] instr_count
);

    // The wait counter only has to hold 0..TIMEOUT_CYCLES-1 missed cycles.
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALTED
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_mem_req;
    logic [WAIT_W-1:0]   r_wait;
    logic                w_in_phase;
    logic                w_done;
    logic                w_expire;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_done     = 1'b0;
        w_in_phase = r_state inside {S_IF, S_ID, S_EX, S_MEM, S_WB};
        case (r_state)
            S_IF:    w_done = if_done;
            S_ID:    w_done = id_done;
            S_EX:    w_done = ex_done;
            S_MEM:   w_done = mem_done;
            S_WB:    w_done = wb_done;
            default: w_done = 1'b0;
        endcase

        // A done arriving on the limit cycle wins over the watchdog.
        w_expire = w_in_phase && !w_done && (r_wait == WAIT_LIMIT);

        w_next = r_state;
        case (r_state)
            S_IDLE:  if (run)      w_next = S_IF;
            S_IF:    if (if_done)  w_next = S_ID;
            S_ID:    if (id_done)  w_next = S_EX;
            S_EX:    if (ex_done)  w_next = r_mem_req ? S_MEM : S_WB;
            S_MEM:   if (mem_done) w_next = S_WB;
            S_WB: begin
                if (wb_done) begin
                    if (halt)     w_next = S_HALTED;
                    else if (run) w_next = S_IF;
                    else          w_next = S_IDLE;
                end
            end
            default: w_next = r_state;
        endcase
        if (w_expire) w_next = S_HALTED;
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_wait      <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            phase_if    <= 1'b0;
            phase_id    <= 1'b0;
            phase_ex    <= 1'b0;
            phase_mem   <= 1'b0;
            phase_wb    <= 1'b0;
            phase_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == S_ID && id_done) r_mem_req <= need_mem;

            if (w_next != r_state)  r_wait <= '0;
            else if (w_in_phase)    r_wait <= r_wait + 1'b1;

            if (r_state == S_WB && wb_done) instr_count <= instr_count + COUNT_W'(1);

            if (w_expire)             timeout <= 1'b1;
            if (w_next == S_HALTED)   halted  <= 1'b1;

            phase_if    <= (w_next == S_IF);
            phase_id    <= (w_next == S_ID);
            phase_ex    <= (w_next == S_EX);
            phase_mem   <= (w_next == S_MEM);
            phase_wb    <= (w_next == S_WB);
            busy        <= w_next inside {S_IF, S_ID, S_EX, S_MEM, S_WB};
            phase_start <= (w_next != r_state) &&
                           (w_next inside {S_IF, S_ID, S_EX, S_MEM, S_WB});
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a cycle model pushes expected outputs,
// which are popped and compared one cycle later against the DUT.
module tb_phase_sequencer;

    localparam int CW = 4;
    localparam int TO = 4;

    localparam int M_IDLE = 0, M_IF = 1, M_ID = 2, M_EX = 3,
                   M_MEM = 4, M_WB = 5, M_HALTED = 6;

    typedef struct {
        logic [4:0]    ph;
        logic          st;
        logic          bz;
        logic          hl;
        logic          to;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, run, halt, need_mem;
    logic if_done, id_done, ex_done, mem_done, wb_done;
    logic phase_if, phase_id, phase_ex, phase_mem, phase_wb;
    logic phase_start, busy, halted, timeout;
    logic [CW-1:0] instr_count;

    phase_sequencer #(.COUNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .halt(halt),
        .if_done(if_done), .id_done(id_done), .ex_done(ex_done),
        .mem_done(mem_done), .wb_done(wb_done), .need_mem(need_mem),
        .phase_if(phase_if), .phase_id(phase_id), .phase_ex(phase_ex),
        .phase_mem(phase_mem), .phase_wb(phase_wb), .phase_start(phase_start),
        .busy(busy), .halted(halted), .timeout(timeout), .instr_count(instr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    int            ms;
    logic          m_memreq, m_halted, m_to, m_start;
    int            m_wait;
    logic [CW-1:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs now applied.
    task automatic model_edge();
        int   nxt;
        logic dn;
        if (reset) begin
            ms = M_IDLE; m_memreq = 0; m_wait = 0; m_cnt = '0;
            m_halted = 0; m_to = 0; m_start = 0;
            return;
        end
        case (ms)
            M_IF:    dn = if_done;
            M_ID:    dn = id_done;
            M_EX:    dn = ex_done;
            M_MEM:   dn = mem_done;
            M_WB:    dn = wb_done;
            default: dn = 1'b0;
        endcase
        nxt = ms;
        if (ms == M_IDLE) begin
            if (run) nxt = M_IF;
        end else if (ms != M_HALTED) begin
            if (dn) begin
                case (ms)
                    M_IF:  nxt = M_ID;
                    M_ID:  begin nxt = M_EX; m_memreq = need_mem; end
                    M_EX:  nxt = m_memreq ? M_MEM : M_WB;
                    M_MEM: nxt = M_WB;
                    default: begin
                        m_cnt = m_cnt + 1'b1;
                        nxt = halt ? M_HALTED : (run ? M_IF : M_IDLE);
                    end
                endcase
            end else if (m_wait + 1 >= TO) begin
                nxt = M_HALTED;
                m_to = 1;
            end else begin
                m_wait++;
            end
        end
        if (nxt == M_HALTED) m_halted = 1;
        m_start = (nxt != ms) && (nxt >= M_IF) && (nxt <= M_WB);
        if (nxt != ms) m_wait = 0;
        ms = nxt;
    endtask

    task automatic step();
        exp_t e;
        exp_t g;
        model_edge();
        e.ph  = {ms == M_WB, ms == M_MEM, ms == M_EX, ms == M_ID, ms == M_IF};
        e.st  = m_start;
        e.bz  = (ms >= M_IF) && (ms <= M_WB);
        e.hl  = m_halted;
        e.to  = m_to;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("phase",       {phase_wb, phase_mem, phase_ex, phase_id, phase_if}, g.ph);
        check("phase_start", phase_start, g.st);
        check("busy",        busy,        g.bz);
        check("halted",      halted,      g.hl);
        check("timeout",     timeout,     g.to);
        check("instr_count", instr_count, g.cnt);
    endtask

    task automatic set_done(input logic v);
        if_done = v; id_done = v; ex_done = v; mem_done = v; wb_done = v;
    endtask

    task automatic do_reset();
        run = 0; halt = 0; need_mem = 0;
        set_done(1'b0);
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        int n_mem;
        ms = M_IDLE; m_memreq = 0; m_wait = 0; m_cnt = '0;
        m_halted = 0; m_to = 0; m_start = 0;
        run = 0; halt = 0; need_mem = 0; reset = 1;
        set_done(1'b0);

        // Reset state
        do_reset();
        check("rst_busy",  busy, 0);
        check("rst_count", instr_count, 0);

        // Back-to-back instructions without MEM: 4 cycles each
        run = 1; set_done(1'b1);
        step();
        repeat (12) step();
        check("b2b_count", instr_count, 3);

        // MEM phase stretched by a late mem_done
        do_reset();
        run = 1; set_done(1'b1); mem_done = 0; need_mem = 1;
        repeat (4) step();
        n_mem = 0;
        for (int i = 0; i < 4; i++) begin
            mem_done = (i == 3);
            if (phase_mem) n_mem++;
            step();
        end
        check("mem_cycles", n_mem, 4);
        check("mem_to_wb",  phase_wb, 1);
        check("wb_start",   phase_start, 1);

        // Halt requested before WB exit
        do_reset();
        run = 1; set_done(1'b1);
        step(); step();
        halt = 1;
        step(); step(); step();
        check("halt_flag",  halted, 1);
        check("halt_count", instr_count, 1);
        halt = 0;
        repeat (4) step();
        check("halt_stays", busy, 0);
        check("halt_count2", instr_count, 1);

        // Watchdog fires in EX
        do_reset();
        run = 1; set_done(1'b1); ex_done = 0;
        repeat (3) step();
        repeat (4) step();
        check("wd_timeout", timeout, 1);
        check("wd_halted",  halted, 1);
        check("wd_count",   instr_count, 0);

        // Done on the limit cycle wins
        do_reset();
        run = 1; set_done(1'b1); ex_done = 0;
        repeat (3) step();
        repeat (3) step();
        ex_done = 1;
        step();
        check("wd_late_wb", phase_wb, 1);
        check("wd_late_to", timeout, 0);

        // Counter wrap at 2^CW instructions
        do_reset();
        run = 1; set_done(1'b1);
        step();
        repeat (15 * 4) step();
        check("wrap_15", instr_count, 15);
        repeat (4) step();
        check("wrap_0", instr_count, 0);

        // Reset in the middle of MEM
        do_reset();
        run = 1; set_done(1'b1); mem_done = 0; need_mem = 1;
        repeat (5) step();
        check("mid_mem", phase_mem, 1);
        reset = 1;
        step();
        check("rst_mem_busy", busy, 0);
        check("rst_mem_phase", phase_mem, 0);
        reset = 0;
        step();
        check("rst_then_if", phase_if, 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) < 4);
            run      = ($urandom_range(0, 99) < 70);
            halt     = ($urandom_range(0, 99) < 5);
            need_mem = $urandom_range(0, 1);
            if_done  = ($urandom_range(0, 99) < 60);
            id_done  = ($urandom_range(0, 99) < 60);
            ex_done  = ($urandom_range(0, 99) < 60);
            mem_done = ($urandom_range(0, 99) < 60);
            wb_done  = ($urandom_range(0, 99) < 60);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter: COUNT_W, default 16, width of retired-instruction counter.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, max cycles a phase waits for its done (range 1..65535).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  permission to start next instruction.
REQ-006 halt  input  1  stop after current WB completes.
REQ-007 if_done, id_done, ex_done, mem_done, wb_done  input  1 each  stage completion acknowledges.
REQ-008 need_mem  input  1  from decode; valid only in a cycle with id_done=1.
REQ-009 phase_if, phase_id, phase_ex, phase_mem, phase_wb  output  1 each  stage enables, at most one high.
REQ-010 phase_start  output  1  high in the first cycle of every phase.
REQ-011 busy  output  1  high in any phase state.
REQ-012 halted  output  1  sticky halt indicator.
REQ-013 timeout  output  1  sticky watchdog flag.
REQ-014 instr_count  output  COUNT_W  retired-instruction count.

Function
REQ-015 States: IDLE, IF, ID, EX, MEM, WB, HALTED; registered Moore outputs decoded from state only.
REQ-016 phase_* high exactly in the matching state; all low in IDLE/HALTED; busy = OR of phase_*.
REQ-017 IDLE -> IF when run=1; else stay.
REQ-018 IF -> ID on if_done; ID -> EX on id_done, latching need_mem into mem_req in that same edge.
REQ-019 EX -> MEM on ex_done if mem_req=1, else EX -> WB.
REQ-020 MEM -> WB on mem_done.
REQ-021 WB on wb_done: instr_count += 1 (modulo 2^COUNT_W, wraps to 0); then halt=1 -> HALTED, else run=1 -> IF, else IDLE.
REQ-022 halt priority over run at WB exit; halt sampled only at WB exit (halt ignored elsewhere).
REQ-023 Done inputs of non-active stages ignored; need_mem ignored unless state=ID and id_done=1.
REQ-024 Latency: done sampled at edge N, next phase visible after edge N; done held high gives 1 cycle per phase (4 cycles/instr without MEM, 5 with).
REQ-025 phase_start = 1 in the first cycle after any state entry into IF/ID/EX/MEM/WB, including WB->IF back-to-back.
REQ-026 Watchdog: wait counter cleared on phase entry, increments each cycle in phase without its done.
REQ-027 Counter reaching TIMEOUT_CYCLES with done still low -> HALTED next edge, timeout=1, halted=1; instr_count unchanged.
REQ-028 Done arriving in the same cycle as the watchdog limit wins: normal transition, no timeout.
REQ-029 HALTED is terminal; only reset leaves it; run/halt/done ignored there.

Reset
REQ-030 reset=1 at a clock edge: state=IDLE, mem_req=0, wait counter=0, instr_count=0, halted=0, timeout=0, all phase_*/phase_start/busy=0.
REQ-031 reset overrides every other input, including mid-phase and in HALTED; first post-reset edge with run=1 enters IF.

Verification
REQ-032 reset, run=1, all done held 1, need_mem=0 -> phase sequence IF,ID,EX,WB repeating, 4 cycles/instr, instr_count=3 after 12 cycles in phases.
REQ-033 need_mem=1 at id_done, mem_done delayed 3 cycles -> EX->MEM, phase_mem high 4 cycles, then WB; phase_start single-cycle at each entry.
REQ-034 halt=1 asserted during EX, wb_done=1 -> HALTED after WB, halted=1, count incremented once, later run/done ignored.
REQ-035 TIMEOUT_CYCLES=4, ex_done never asserted -> HALTED after 4 cycles in EX, timeout=1; repeat with ex_done on 4th cycle -> WB, timeout=0.
REQ-036 COUNT_W=4, 16 instructions retired -> instr_count wraps 15->0; reset asserted mid-MEM -> IDLE, all outputs 0 next cycle.
